// File: rtl/mips_lsu_if.sv
// Core-side request/response channel and RAM-side port of the MIPS load/store unit.
// slave is the LSU view; master is the view of the surrounding core and RAM.
interface mips_lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_lsu.sv
// MIPS load/store unit: byte-addressed core requests to a word-wide RAM without byte
// enables, with lane extraction/extension on loads and read-modify-write on sub-word stores.
module mips_lsu #(
    parameter int MEM_WORDS = 128,
    parameter int ADDR_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mips_lsu_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DATA  = 3'd2,
        WR       = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MEM_WORDS_L = MEM_WORDS[ADDR_W:0];

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              accept_s;
    logic              req_err_s;
    logic [ADDR_W-1:0] req_idx_s;

    // Lane select and sign/zero extension of a loaded word (little-endian lanes).
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the old RAM word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8]     = wd[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = wd;
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept_s  = bus.req_valid && req_ready_q;
    assign req_idx_s = bus.req_addr[ADDR_W+1:2];
    assign req_err_s = (bus.req_size == 2'b11)
                    || ((bus.req_size == 2'b01) && bus.req_addr[0])
                    || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                    || (bus.req_addr[31:ADDR_W+2] != '0)
                    || ({1'b0, req_idx_s} >= MEM_WORDS_L);

    // Next-state and next-output computation for the request sequencer.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_rw_d    = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    we_d        = bus.req_we;
                    size_d      = bus.req_size;
                    signed_d    = bus.req_signed;
                    off_d       = bus.req_addr[1:0];
                    wdata_d     = bus.req_wdata[15:0];
                    mem_addr_d  = req_idx_s;
                    req_ready_d = 1'b0;
                    if (req_err_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = RESP;
                    end else if (!bus.req_we || (bus.req_size != 2'b10)) begin
                        state_d = RD_ISSUE;
                    end else begin
                        mem_wdata_d = bus.req_wdata;
                        mem_rw_d    = 1'b0;
                        state_d     = WR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (!we_q) begin
                    rsp_rdata_d = load_extract(bus.mem_rdata, off_q, size_q, signed_q);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    mem_wdata_d = store_merge(bus.mem_rdata, off_q, size_q, wdata_q);
                    mem_rw_d    = 1'b0;
                    state_d     = WR;
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    // The RAM writes whenever mem_rw is low, so reset must block it without waiting for an edge.
    assign bus.mem_rw    = mem_rw_q | ~rst_n;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu: a RAM model, a response scoreboard fed by the stimulus,
// and a monitor that pops and compares on every response handshake.
module tb_mips_lsu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_lsu_if #(.ADDR_W(8)) bus();
    mips_lsu #(.MEM_WORDS(128), .ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] ram [0:255];

    // Single-port RAM: write while mem_rw is low, read data registered one edge later.
    always @(posedge clk) begin
        if (!bus.mem_rw) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b expected no response",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check32("sb_rdata", bus.rsp_rdata, e.rdata);
                check32("sb_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wr, input int hold);
        int lat;
        int wr_cnt;
        bit seen;
        lat = 0;
        wr_cnt = 0;
        seen = 1'b0;
        @(negedge clk);
        check32({name, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.rsp_ready  = (hold == 0);
        sb_q.push_back({exp_rdata, exp_err});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_rw === 1'b0) wr_cnt++;
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                lat = i;
            end
        end
        check32({name, "_latency"}, lat, exp_lat);
        if (seen && hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.mem_rw === 1'b0) wr_cnt++;
                check32({name, "_stall_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
                check32({name, "_stall_rdata"}, bus.rsp_rdata, exp_rdata);
                check32({name, "_stall_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
            end
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        check32({name, "_ram_writes"}, wr_cnt, exp_wr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[5] = 32'h8899AABB;
        ram[8] = 32'h12345678;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check32("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check32("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check32("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        check32("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        check32("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        //      name         we    size   sgn   addr          wdata         exp_rdata     err  lat wr hold
        do_req("ld_word",    1'b0, 2'b10, 1'b0, 32'h00000014, 32'd0,        32'h8899AABB, 1'b0, 3, 0, 0);
        do_req("ld_byte_s",  1'b0, 2'b00, 1'b1, 32'h00000015, 32'd0,        32'hFFFFFFAA, 1'b0, 3, 0, 0);
        do_req("ld_byte_u",  1'b0, 2'b00, 1'b0, 32'h00000015, 32'd0,        32'h000000AA, 1'b0, 3, 0, 0);
        do_req("ld_half_s",  1'b0, 2'b01, 1'b1, 32'h00000016, 32'd0,        32'hFFFF8899, 1'b0, 3, 0, 0);
        do_req("st_byte",    1'b1, 2'b00, 1'b0, 32'h00000017, 32'h00000011, 32'd0,        1'b0, 4, 1, 0);
        check32("ram5_after_sb", ram[5], 32'h1199AABB);
        do_req("ld_half_s2", 1'b0, 2'b01, 1'b1, 32'h00000014, 32'd0,        32'hFFFFAABB, 1'b0, 3, 0, 0);
        do_req("ld_half_u",  1'b0, 2'b01, 1'b0, 32'h00000014, 32'd0,        32'h0000AABB, 1'b0, 3, 0, 0);
        do_req("st_word127", 1'b1, 2'b10, 1'b0, 32'h000001FC, 32'hDEADBEEF, 32'd0,        1'b0, 2, 1, 0);
        check32("ram127", ram[127], 32'hDEADBEEF);
        do_req("st_word128", 1'b1, 2'b10, 1'b0, 32'h00000200, 32'h01020304, 32'd0,        1'b1, 1, 0, 0);
        do_req("ld_half_mis",1'b0, 2'b01, 1'b1, 32'h00000015, 32'd0,        32'd0,        1'b1, 1, 0, 0);
        do_req("st_word_mis",1'b1, 2'b10, 1'b0, 32'h00000016, 32'hFFFFFFFF, 32'd0,        1'b1, 1, 0, 0);
        do_req("size_rsvd",  1'b0, 2'b11, 1'b0, 32'h00000014, 32'd0,        32'd0,        1'b1, 1, 0, 0);
        do_req("ld_hi_addr", 1'b0, 2'b10, 1'b0, 32'h10000000, 32'd0,        32'd0,        1'b1, 1, 0, 0);
        check32("ram5_after_errs", ram[5], 32'h1199AABB);
        do_req("st_half",    1'b1, 2'b01, 1'b0, 32'h0000001E, 32'h1234BEEF, 32'd0,        1'b0, 4, 1, 0);
        check32("ram7_after_sh", ram[7], 32'hBEEF0000);
        do_req("ld_word7",   1'b0, 2'b10, 1'b0, 32'h0000001C, 32'd0,        32'hBEEF0000, 1'b0, 3, 0, 0);
        do_req("ld_stall",   1'b0, 2'b10, 1'b0, 32'h00000014, 32'd0,        32'h1199AABB, 1'b0, 3, 0, 5);

        // Reset asserted during the WR cycle of a word store must suppress the write.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b10;
        bus.req_addr   = 32'h00000020;
        bus.req_wdata  = 32'hCAFEF00D;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check32("rstwr_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check32("rstwr_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check32("rstwr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check32("rstwr_mem_rw2", {31'd0, bus.mem_rw}, 32'd1);
        check32("rstwr_ram8", ram[8], 32'h12345678);
        @(posedge clk);
        #1;
        do_req("ld_word8",   1'b0, 2'b10, 1'b0, 32'h00000020, 32'd0,        32'h12345678, 1'b0, 3, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending responses expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Load/store unit for the MIPS datapath; the initiator that drives the single-port word-wide data RAM.
- Accepts byte-addressed load/store requests from the core and translates them into RAM word accesses.
- Performs byte/halfword extraction with sign or zero extension on loads.
- Performs read-modify-write for sub-word stores, because the RAM has no byte enables.
- Flags misaligned, out-of-range and reserved-size requests without touching the RAM.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in the data RAM; the valid word index range is 0..MEM_WORDS-1.
- ADDR_W, 8, width of the RAM word-address port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  core request present.
- req_ready  output  1  LSU can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present; held until rsp_ready.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  request rejected (misaligned, out of range, or reserved size).
- mem_rw  output  1  RAM control; 1 = read, 0 = write (RAM port convention).
- mem_addr  output  ADDR_W  RAM word address.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, registered by the RAM one edge after a read-mode address.

Behaviour:
- Reset (rst_n low at an edge):
  - state <= IDLE; rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata <= 0.
  - mem_rw is forced to 1 combinationally whenever rst_n = 0, so no RAM write can occur on a reset edge, even mid-operation.
  - An in-flight request is dropped with no response.
- mem_rw = 0 only in state WR. The RAM writes on every edge while mem_rw = 0, so all other states, including IDLE, hold read mode.
- Acceptance: the request is accepted on an edge where req_valid && req_ready. The address, size, sign, data and we fields are latched at that edge.
- Checks on the latched request:
  - Word index = addr[ADDR_W+1:2].
  - Error if req_size = 11.
  - Error if size = 01 and addr[0] = 1.
  - Error if size = 10 and addr[1:0] != 0.
  - Error if addr[31:ADDR_W+2] != 0.
  - Error if word index >= MEM_WORDS.
- Byte lanes are little-endian; byte offset k occupies bits [8k+7:8k].
- States:
  - IDLE: req_ready = 1. On accept:
    - error -> RESP with rsp_err = 1;
    - load or sub-word store -> RD_ISSUE;
    - word store -> WR.
  - RD_ISSUE: mem_rw = 1, mem_addr = word index. -> RD_DATA.
  - RD_DATA: mem_rdata is valid in this cycle.
    - Load: extract the lane, extend it, and register into rsp_rdata. -> RESP.
    - Sub-word store: merge req_wdata into the addressed lane(s) of mem_rdata, register the result as mem_wdata. -> WR.
  - WR: mem_rw = 0, mem_addr = word index, mem_wdata = full word (word store) or merged word. Exactly one cycle. -> RESP.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are stable while waiting. On rsp_ready: clear rsp_valid, rsp_err and rsp_rdata -> IDLE.
- Latency, counted from the accept edge to the first rsp_valid cycle, with rsp_ready held high:
  - error: 1 cycle;
  - word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles.
- Back-to-back: the earliest next accept is the cycle after the RESP handshake, because req_ready is low in RESP. There is no overlap of requests.
- Stalling: rsp_ready held low keeps RESP indefinitely with no RAM activity; mem_rw stays at 1.
- req_valid while busy is ignored; the core must hold it until req_ready.

Test Plan:
- Word load: RAM word 5 = 0x8899AABB; load word at addr 0x14 -> rsp_rdata = 0x8899AABB, rsp_err = 0, rsp_valid 3 cycles after accept.
- Sub-word loads from the same word:
  - byte at 0x15, signed -> 0xFFFFFFAA; unsigned -> 0x000000AA;
  - half at 0x16, signed -> 0xFFFF8899.
- Byte store, read-modify-write: byte 0x11 to addr 0x17 -> RAM word 5 becomes 0x1199AABB; mem_rw is low for exactly one cycle; rsp_valid 4 cycles after accept.
- Word store: store 0xDEADBEEF to 0x1FC (word 127) -> RAM word 127 = 0xDEADBEEF; then store to 0x200 -> rsp_err = 1, mem_rw never low.
- Alignment errors:
  - half load at 0x15 -> rsp_err = 1, rsp_rdata = 0;
  - word store at 0x16 -> rsp_err = 1;
  - size 11 -> rsp_err = 1.
- Reset and backpressure:
  - Assert rst_n = 0 during the WR cycle of a store -> RAM word unchanged, mem_rw = 1, state IDLE next cycle.
  - Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata are stable, req_ready = 0 throughout.
